pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined successor to the single-cycle `full_adder`. It adds or subtracts two `WIDTH`-bit operands by splitting them into `CHUNK`-bit slices, one slice per pipeline stage, and registering the carry between stages. Operands are skewed in and results are de-skewed out, so throughput is one operation per cycle. Sits in the CORDIC/trig datapath wherever wide add/sub must close timing, with a valid/ready handshake for back-pressure.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width; must be ≥ 2.
- `CHUNK`, 4: bits added per stage; must be ≥ 1 and ≤ `WIDTH`.
- `STAGES`: derived, not user-set; equals ceil(`WIDTH`/`CHUNK`). The last slice may be narrower than `CHUNK`.

Ports:
- `clock`, in, 1: single clock; all state is on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `io_in_valid`, in, 1: operand beat valid.
- `io_in_ready`, out, 1: the block can accept a beat.
- `io_in_a`, in, `WIDTH`: operand A.
- `io_in_b`, in, `WIDTH`: operand B.
- `io_in_sub`, in, 1: 1 selects A − B; 0 selects A + B + cin.
- `io_in_cin`, in, 1: carry-in; used only when `io_in_sub` = 0.
- `io_in_sat`, in, 1: present only under `PIPELINED_ADDER_SAT_EN`; requests signed saturation.
- `io_out_valid`, out, 1: result valid.
- `io_out_ready`, in, 1: downstream accepts the result.
- `io_out_s`, out, `WIDTH`: sum or difference.
- `io_out_c`, out, 1: carry out of the MSB. For subtract, 1 means no borrow.
- `io_out_v`, out, 1: two's-complement signed overflow.

## Operation
- **Accept.** A beat is accepted when `io_in_valid` and `io_in_ready` are both high.
- **Subtract.** When `io_in_sub` = 1, B is inverted and the stage-0 carry-in is forced to 1. Otherwise the stage-0 carry-in is `io_in_cin`.
- **Per stage.** Stage k computes slice k as {carry, sum} = A[k] + B'[k] + carry_in(k). The carry is registered and feeds stage k+1.
  - Slices not yet consumed travel in skew registers alongside the carry.
  - Completed result slices travel in de-skew registers.
- **Overflow.** `io_out_v` = (A[MSB] == B'[MSB]) and (S[MSB] != A[MSB]). It is computed in the final stage using the delayed operand MSBs.
- **Valid tracking.** Each stage carries its own valid bit. Bubbles propagate as invalid stages and are not compacted.
- **Global enable.** en = !`io_out_valid` or `io_out_ready`.
  - When en = 0, all stage registers hold.
  - `io_in_ready` = en, combinationally.
- **Stage payload.** A stage whose valid bit is 0 keeps its data registers unchanged. Outputs are therefore qualified only by `io_out_valid`.
- **Ordering.** Results leave in acceptance order. No operation is dropped or duplicated under any back-pressure pattern.

## Timing
- **Reset.** All valid bits, data registers and carries clear asynchronously to 0. After reset, `io_out_valid`, `io_out_s`, `io_out_c` and `io_out_v` all read 0.
- **`io_in_ready` during reset.** It reads 1 once reset deasserts, and is also 1 while reset is asserted.
- **Latency.** A beat accepted at edge t is presented on the outputs after edge t+`STAGES`−1, provided en = 1 throughout. `io_out_valid` is driven from the last stage register.
- **Throughput.** One operation per cycle while `io_out_ready` = 1.
- **Stall.** If `io_out_valid` = 1 and `io_out_ready` = 0:
  - every stage freezes;
  - `io_in_ready` = 0;
  - the presented result stays stable until it is consumed.
- **Simultaneous events.** With a full pipe and `io_out_ready` = 1, the output is consumed and a new input is accepted on the same edge.
- **Reset mid-operation.** Asserting reset mid-stream discards every in-flight operation immediately. No partial result appears.
- **`STAGES` = 1.** Degenerates to a registered adder with latency 1.

## Configuration
- **`PIPELINED_ADDER_SAT_EN` defined:**
  - the `io_in_sat` port exists and is carried down the pipe with its beat;
  - when the beat's sat bit is 1 and `io_out_v` = 1, `io_out_s` clamps to 0x7F..F if A was non-negative, or 0x80..0 if A was negative;
  - `io_out_v` and `io_out_c` still report the raw, unsaturated flags.
- **Not defined:**
  - no `io_in_sat` port and no extra registers;
  - the result always wraps modulo 2^`WIDTH`.

## Test plan
All scenarios use `WIDTH`=16, `CHUNK`=4 (so `STAGES`=4).
1. **Reset values.** Assert reset for 3 cycles → `io_out_valid`=0, `io_out_s`=0x0000, `io_out_c`=0, `io_out_v`=0, `io_in_ready`=1.
2. **Cross-slice carry.** Add 0x00FF + 0x0001, cin=0 → `io_out_s`=0x0100, c=0, v=0, valid exactly 4 edges after acceptance. Add 0xFFFF + 0x0001 → s=0x0000, c=1, v=0.
3. **Subtract and overflow.** 0x0005 − 0x0007 → s=0xFFFE, c=0, v=0. 0x8000 − 0x0001 → s=0x7FFF, c=1, v=1. 0x1234 + 0x0000 with cin=1 → s=0x1235.
4. **Back-pressure.** Stream 8 beats with A=i, B=0x0100·i for i = 0..7; hold `io_out_ready`=0 for 4 cycles mid-stream → `io_in_ready` drops while stalled, results arrive in order as 0x0101·i, none lost or duplicated.
5. **Bubbles and reset.**
   - Alternate `io_in_valid` 1/0 → `io_out_valid` alternates with the same spacing.
   - Pulse reset with 3 beats in flight → no valid output follows.
6. **`PIPELINED_ADDER_SAT_EN` defined.**
   - 0x7FFF + 0x0001 with sat=1 → s=0x7FFF, v=1.
   - 0x8000 − 0x0001 with sat=1 → s=0x8000, v=1.
   - 0x7FFF + 0x0001 with sat=0 → s=0x8000.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for pipelined_adder: operand beat in, result beat out.
// Pure wiring, no latency.
// Valid/ready on both sides; io_in_ready is the adder's global stage enable.
// Defining PIPELINED_ADDER_SAT_EN adds the io_in_sat request bit.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_a;
    logic [WIDTH-1:0] io_in_b;
    logic             io_in_sub;
    logic             io_in_cin;
`ifdef PIPELINED_ADDER_SAT_EN
    logic             io_in_sat;
`endif
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_s;
    logic             io_out_c;
    logic             io_out_v;

    // Adder side: consumes operands, produces results.
    modport slave (
`ifdef PIPELINED_ADDER_SAT_EN
        input  io_in_sat,
`endif
        input  io_in_valid, io_in_a, io_in_b, io_in_sub, io_in_cin, io_out_ready,
        output io_in_ready, io_out_valid, io_out_s, io_out_c, io_out_v
    );

    // Requester side: produces operands, consumes results.
    modport master (
`ifdef PIPELINED_ADDER_SAT_EN
        output io_in_sat,
`endif
        output io_in_valid, io_in_a, io_in_b, io_in_sub, io_in_cin, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_s, io_out_c, io_out_v
    );
endinterface

// File: rtl/pipelined_adder.sv
// Carry-pipelined add/sub: CHUNK bits per stage, carry registered between stages.
// Latency STAGES cycles (accept edge t -> result after edge t+STAGES-1), 1 op/cycle.
// Global enable: a held output (valid && !ready) freezes every stage and drops io_in_ready.
// Optional signed saturation is built when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    pipelined_adder_if.slave io
);
    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LAST   = STAGES - 1;
    // Operand skew registers exist only between stages; keep at least one entry
    // so the declaration stays legal when the pipe degenerates to a single stage.
    localparam int SKEW   = (STAGES > 1) ? STAGES - 1 : 1;

    logic             en;

    // Stage registers: stage k holds carry out of slice k and result slices 0..k.
    logic             vld_q [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             v_q;

    // Skew registers carry the operands (B already inverted for subtract).
    logic [WIDTH-1:0] a_q   [SKEW];
    logic [WIDTH-1:0] b_q   [SKEW];

    // Per-stage inputs and combinational slice results.
    logic             st_vld [STAGES];
    logic             st_c   [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_s   [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];
    logic             c_d    [STAGES];
    logic [WIDTH-1:0] sd;
    logic             cr;
    logic             v_d;
    logic [WIDTH-1:0] s_fin;

`ifdef PIPELINED_ADDER_SAT_EN
    logic             sat_q  [SKEW];
    logic             st_sat [STAGES];
`endif

    assign en             = !vld_q[LAST] || io.io_out_ready;
    assign io.io_in_ready = en;
    assign io.io_out_valid = vld_q[LAST];
    assign io.io_out_s    = s_q[LAST];
    assign io.io_out_c    = c_q[LAST];
    assign io.io_out_v    = v_q;

    // Stage inputs: stage 0 from the port (subtract = invert B, carry-in 1), others from the previous stage.
    always_comb begin
        st_vld[0] = io.io_in_valid;
        st_c[0]   = io.io_in_sub | io.io_in_cin;
        st_a[0]   = io.io_in_a;
        st_b[0]   = io.io_in_sub ? ~io.io_in_b : io.io_in_b;
        st_s[0]   = '0;
`ifdef PIPELINED_ADDER_SAT_EN
        st_sat[0] = io.io_in_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            st_vld[k] = vld_q[k-1];
            st_c[k]   = c_q[k-1];
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_s[k]   = s_q[k-1];
`ifdef PIPELINED_ADDER_SAT_EN
            st_sat[k] = sat_q[k-1];
`endif
        end
    end

    // Ripple each stage's own slice; the final slice may be narrower than CHUNK.
    always_comb begin
        cr = 1'b0;
        sd = '0;
        for (int k = 0; k < STAGES; k++) begin
            cr = st_c[k];
            sd = st_s[k];
            for (int i = 0; i < WIDTH; i++) begin
                if (i / CHUNK == k) begin
                    sd[i] = st_a[k][i] ^ st_b[k][i] ^ cr;
                    cr    = (st_a[k][i] & st_b[k][i]) | (cr & (st_a[k][i] ^ st_b[k][i]));
                end
            end
            s_d[k] = sd;
            c_d[k] = cr;
        end
    end

    // Final stage: signed overflow from the delayed operand MSBs, optional clamp.
    always_comb begin
        v_d   = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                (s_d[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
        s_fin = s_d[LAST];
`ifdef PIPELINED_ADDER_SAT_EN
        if (st_sat[LAST] && v_d) begin
            s_fin = st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Advance all stages together; a stage loads payload only when its incoming beat is valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                s_q[k]   <= '0;
            end
            for (int k = 0; k < SKEW; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
`ifdef PIPELINED_ADDER_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            v_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= st_vld[k];
                if (st_vld[k]) begin
                    c_q[k] <= c_d[k];
                    s_q[k] <= (k == LAST) ? s_fin : s_d[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (st_vld[k]) begin
                    a_q[k]   <= st_a[k];
                    b_q[k]   <= st_b[k];
`ifdef PIPELINED_ADDER_SAT_EN
                    sat_q[k] <= st_sat[k];
`endif
                end
            end
            if (st_vld[LAST]) begin
                v_q <= v_d;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at WIDTH=16, CHUNK=4 (four stages).
// Expected values are hand-computed constants or simple closed forms.
module tb_pipelined_adder;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One isolated operation: checks latency and all three result fields.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin,
                         input logic [15:0] es, input logic ec, input logic ev);
        int n;
        bus.io_in_a     = a;
        bus.io_in_b     = b;
        bus.io_in_sub   = sub;
        bus.io_in_cin   = cin;
        bus.io_in_valid = 1'b1;
        step();
        bus.io_in_valid = 1'b0;
        n = 1;
        while (!bus.io_out_valid && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_s"}, bus.io_out_s, es);
        chk({tag, "_c"}, bus.io_out_c, ec);
        chk({tag, "_v"}, bus.io_out_v, ev);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, seen;
        logic [15:0] held;
        logic exp_v;

        bus.io_in_valid  = 1'b0;
        bus.io_in_a      = '0;
        bus.io_in_b      = '0;
        bus.io_in_sub    = 1'b0;
        bus.io_in_cin    = 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
        bus.io_in_sat    = 1'b0;
`endif
        bus.io_out_ready = 1'b1;

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rdy_in_reset", bus.io_in_ready, 1);
        reset = 1'b0;
        #1;
        chk("rst_vld", bus.io_out_valid, 0);
        chk("rst_s", bus.io_out_s, 0);
        chk("rst_c", bus.io_out_c, 0);
        chk("rst_v", bus.io_out_v, 0);
        chk("rst_rdy", bus.io_in_ready, 1);
        step();

        // Carry across slices, subtract, overflow, carry-in
        do_op("add_ff",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        do_op("add_cin",  16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0);
        do_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

`ifdef PIPELINED_ADDER_SAT_EN
        bus.io_in_sat = 1'b1;
        do_op("sat_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        do_op("sat_neg",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
        bus.io_in_sat = 1'b0;
        do_op("sat_off",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif

        // Back-pressure: 8 beats, output stalled for cycles 5..8
        sent = 0;
        recv = 0;
        held = '0;
        bus.io_in_sub = 1'b0;
        bus.io_in_cin = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            bus.io_out_ready = !(cyc >= 5 && cyc < 9);
            bus.io_in_valid  = (sent < 8);
            bus.io_in_a      = 16'(sent);
            bus.io_in_b      = 16'(sent << 8);
            #1;
            if (!bus.io_out_ready && bus.io_out_valid) begin
                chk("bp_stall_rdy", bus.io_in_ready, 0);
                if (cyc == 5) held = bus.io_out_s;
                else chk("bp_hold", bus.io_out_s, held);
            end
            if (bus.io_out_valid && bus.io_out_ready) begin
                chk("bp_data", bus.io_out_s, 32'(16'h0101 * recv));
                recv++;
            end
            if (bus.io_in_valid && bus.io_in_ready) sent++;
            step();
        end
        chk("bp_count", recv, 8);
        bus.io_in_valid  = 1'b0;
        bus.io_out_ready = 1'b1;
        repeat (6) step();
        chk("bp_drain", bus.io_out_valid, 0);

        // Bubbles keep their spacing
        for (int j = 0; j < 14; j++) begin
            bus.io_in_valid = (j < 6) && (j % 2 == 0);
            bus.io_in_a     = 16'(j * 3 + 1);
            bus.io_in_b     = 16'h0100;
            #1;
            exp_v = (j >= 4) && (j < 10) && ((j - 4) % 2 == 0);
            chk("bub_vld", bus.io_out_valid, exp_v);
            if (exp_v) chk("bub_s", bus.io_out_s, 32'((j - 4) * 3 + 1 + 256));
            step();
        end

        // Reset with three beats in flight
        for (int j = 0; j < 3; j++) begin
            bus.io_in_valid = 1'b1;
            bus.io_in_a     = 16'(j + 1);
            bus.io_in_b     = 16'h0001;
            step();
        end
        bus.io_in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            if (bus.io_out_valid) seen++;
        end
        chk("rstm_flush", seen, 0);
        chk("rstm_s", bus.io_out_s, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
